sw_event_capture: RTL and testbench
===================================

SW_EVENT_CAPTURE -- requirements
Module: sw_event_capture

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of each per-channel event counter (legal range 1..16).
REQ-002 Parameter TS_W, default 32, sets the width of the timestamp counter (legal range 1..32).
REQ-003 Port PCLK, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port PRESET, input, 1: reset, asynchronous, active-high.
REQ-005 Port PSEL, input, 1: APB3 peripheral select.
REQ-006 Port PENABLE, input, 1: APB3 access phase.
REQ-007 Port PWRITE, input, 1: APB3 direction; 1 = write.
REQ-008 Port PADDR, input, 32: APB3 address; only PADDR[7:0] SHALL be decoded.
REQ-009 Port PWDATA, input, 32: APB3 write data.
REQ-010 Port PRDATA, output, 32: APB3 read data.
REQ-011 Port PREADY, output, 1: tied to 1; no wait states.
REQ-012 Port PSLVERR, output, 1: APB3 error response.
REQ-013 Port EV_IN, input, 2: one-PCLK-wide switch event pulses from the switch debounce/pulse stage; bit n is channel n.
REQ-014 Port IRQ, output, 1: level interrupt to the processor fabric-interrupt input.

Function
REQ-015 Access SHALL be defined as PSEL & PENABLE; a write SHALL be an access with PWRITE=1; a read SHALL be an access with PWRITE=0.
REQ-016 Register map (byte offsets): 0x00 STATUS, 0x04 MASK, 0x08 COUNT0, 0x0C COUNT1, 0x10 TS0, 0x14 TS1, 0x18 TSNOW.
REQ-017 Unused upper bits of every register SHALL read 0.
REQ-018 STATUS[1:0] holds the pending bits, one per channel.
REQ-019 STATUS SHALL be write-1-to-clear; writing 0 to a bit SHALL leave it unchanged.
REQ-020 MASK[1:0] SHALL be read/write; a 1 enables that channel onto IRQ.
REQ-021 EV_IN[n]=1 SHALL set pending[n] on the next edge.
REQ-022 If EV_IN[n]=1 coincides with a W1C of bit n, the event SHALL win and pending[n] SHALL end at 1.
REQ-023 EV_IN[n]=1 SHALL increment COUNTn by 1 and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-024 Any write to COUNTn SHALL clear it to 0.
REQ-025 If a write to COUNTn coincides with EV_IN[n]=1, COUNTn SHALL become 1.
REQ-026 COUNTn SHALL be read-only apart from that clear.
REQ-027 Both EV_IN bits asserted in the same cycle SHALL each be captured independently.
REQ-028 IRQ SHALL be registered: IRQ = |(pending & MASK), evaluated on the previous cycle's state, giving 1 cycle of latency from the pending/MASK update to IRQ.
REQ-029 PRDATA SHALL be combinational from PADDR[7:0] and SHALL be valid during any read access.
REQ-030 PRDATA SHALL be 0 whenever no read access is in progress.
REQ-031 PSLVERR SHALL be 1 during an access to an offset not listed in REQ-016, and 0 otherwise.
REQ-032 A write with PSLVERR=1 SHALL modify no state; a read with PSLVERR=1 SHALL return 0.
REQ-033 Writes to TS0, TS1 and TSNOW SHALL be ignored and SHALL NOT raise PSLVERR.

Reset
REQ-034 PRESET=1 SHALL immediately clear, without waiting for PCLK, all of: pending, MASK, COUNT0, COUNT1, TS0, TS1, the timestamp counter and IRQ.
REQ-035 Events arriving while PRESET=1 SHALL be discarded.
REQ-036 Assertion of PRESET mid-access SHALL abort the access with no state change.
REQ-037 PREADY SHALL be 1 throughout reset.

Configuration
REQ-038 Macro EVT_TIMESTAMP_EN defined: a free-running TS_W-bit counter SHALL increment every PCLK and wrap to 0.
REQ-039 With EVT_TIMESTAMP_EN defined, EV_IN[n] SHALL load TSn with the counter value present in the event cycle, and TSNOW SHALL read the live counter.
REQ-040 Macro EVT_TIMESTAMP_EN undefined: the counter and TS registers SHALL NOT be synthesised; 0x10/0x14/0x18 SHALL remain mapped (no PSLVERR) and SHALL read 0.

Verification
REQ-041 MASK=0x3, then a 1-cycle pulse on EV_IN=2'b01 -> STATUS=0x1 and COUNT0=1 on the next read; IRQ rises 2 edges after the pulse edge.
REQ-042 A W1C of STATUS=0x1 in the same cycle as EV_IN[0]=1 -> STATUS still 0x1 and COUNT0 incremented.
REQ-043 260 pulses on EV_IN[1] with CNT_W=8 -> COUNT1=255; then a write to COUNT1 -> COUNT1 reads 0.
REQ-044 EV_IN=2'b11 in one cycle with MASK=0x2 -> STATUS=0x3 and IRQ=1; W1C of 0x2 -> IRQ=0 one cycle later while STATUS=0x1.
REQ-045 Read of offset 0x1C -> PSLVERR=1 and PRDATA=0; write 0x3 to 0x20 -> MASK unchanged.
REQ-046 With EVT_TIMESTAMP_EN, event at counter value 0x64 -> TS0=0x64; assert PRESET asynchronously mid-cycle -> all registers read 0 and IRQ=0 before the next PCLK edge.

Source files
------------

// File: rtl/sw_event_capture.sv
// Two-channel switch event capture: pending/mask/IRQ, saturating counters, APB3 register access.
// Define EVT_TIMESTAMP_EN to build the free-running timestamp counter and per-channel TS registers.
module sw_event_capture #(
    parameter int CNT_W = 8,
    parameter int TS_W  = 32
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [1:0]  EV_IN,
    output logic        IRQ
);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_MASK   = 8'h04;
    localparam logic [7:0] OFF_COUNT0 = 8'h08;
    localparam logic [7:0] OFF_COUNT1 = 8'h0C;
    localparam logic [7:0] OFF_TS0    = 8'h10;
    localparam logic [7:0] OFF_TS1    = 8'h14;
    localparam logic [7:0] OFF_TSNOW  = 8'h18;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [7:0]  off;
    logic        access;
    logic        addr_ok;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  w1c;
    logic [31:0] rdata;

    logic [1:0]            pending_q, pending_d;
    logic [1:0]            mask_q, mask_d;
    logic [1:0][CNT_W-1:0] count_q, count_d;
    logic                  irq_q, irq_d;

    logic unused_bits;
    assign unused_bits = ^{PADDR[31:8], PWDATA[31:2]};

    assign off    = PADDR[7:0];
    assign access = PSEL & PENABLE;

    always_comb begin
        case (off)
            OFF_STATUS, OFF_MASK, OFF_COUNT0, OFF_COUNT1,
            OFF_TS0, OFF_TS1, OFF_TSNOW: addr_ok = 1'b1;
            default:                     addr_ok = 1'b0;
        endcase
    end

    // Erroring accesses are dropped entirely: no write side effects, zero read data.
    assign wr_en   = access & PWRITE & addr_ok;
    assign rd_en   = access & ~PWRITE & addr_ok;
    assign PSLVERR = access & ~addr_ok;
    assign PREADY  = 1'b1;

    always_comb begin
        w1c       = (wr_en && off == OFF_STATUS) ? PWDATA[1:0] : 2'b00;
        pending_d = (pending_q & ~w1c) | EV_IN;
        mask_d    = (wr_en && off == OFF_MASK) ? PWDATA[1:0] : mask_q;
        irq_d     = |(pending_q & mask_q);
    end

    always_comb begin
        count_d = count_q;
        for (int n = 0; n < 2; n++) begin
            if (wr_en && off == ((n == 0) ? OFF_COUNT0 : OFF_COUNT1)) begin
                count_d[n] = EV_IN[n] ? CNT_ONE : '0;
            end else if (EV_IN[n] && count_q[n] != CNT_MAX) begin
                count_d[n] = count_q[n] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pending_q <= '0;
            mask_q    <= '0;
            count_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
        end
    end

    assign IRQ = irq_q;

`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0]      ts_cnt_q, ts_cnt_d;
    logic [1:0][TS_W-1:0] ts_q, ts_d;

    // Each TS register captures the counter value seen in the event cycle itself.
    always_comb begin
        ts_cnt_d = ts_cnt_q + TS_W'(1);
        ts_d     = ts_q;
        for (int n = 0; n < 2; n++) begin
            if (EV_IN[n]) begin
                ts_d[n] = ts_cnt_q;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
        end
    end
`else
    logic [TS_W-1:0] unused_ts;
    assign unused_ts = '0;
`endif

    always_comb begin
        rdata = '0;
        case (off)
            OFF_STATUS: rdata = {30'b0, pending_q};
            OFF_MASK:   rdata = {30'b0, mask_q};
            OFF_COUNT0: rdata = 32'(count_q[0]);
            OFF_COUNT1: rdata = 32'(count_q[1]);
`ifdef EVT_TIMESTAMP_EN
            OFF_TS0:    rdata = 32'(ts_q[0]);
            OFF_TS1:    rdata = 32'(ts_q[1]);
            OFF_TSNOW:  rdata = 32'(ts_cnt_q);
`endif
            default:    rdata = '0;
        endcase
    end

    assign PRDATA = rd_en ? rdata : 32'h0;

endmodule

// File: tb/tb_sw_event_capture.sv
// Bench for sw_event_capture: directed scenarios plus randomized APB/event traffic against a behavioural model.
module tb_sw_event_capture;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR, IRQ;
    logic [1:0]  EV_IN;

    int tests = 0;
    int fails = 0;

    localparam int CNT_MAX = 255;

    sw_event_capture #(.CNT_W(8), .TS_W(32)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .EV_IN(EV_IN), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Behavioural model
    logic [1:0]  m_pend, m_mask;
    int          m_cnt [2];
    logic        m_irq;
    logic [31:0] m_ts_cnt;
    logic [31:0] m_ts [2];

    function automatic bit legal(input logic [7:0] o);
        return o inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [7:0] o);
        case (o)
            8'h00: return 32'(m_pend);
            8'h04: return 32'(m_mask);
            8'h08: return 32'(m_cnt[0]);
            8'h0C: return 32'(m_cnt[1]);
`ifdef EVT_TIMESTAMP_EN
            8'h10: return m_ts[0];
            8'h14: return m_ts[1];
            8'h18: return m_ts_cnt;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_pend = 0; m_mask = 0; m_irq = 0; m_ts_cnt = 0;
        for (int n = 0; n < 2; n++) begin m_cnt[n] = 0; m_ts[n] = 0; end
    endtask

    task automatic model_edge();
        logic [7:0] o;
        bit         wr;
        logic       new_irq;
        if (PRESET) begin
            m_reset();
        end else begin
            o  = PADDR[7:0];
            wr = PSEL && PENABLE && PWRITE && legal(o);
            new_irq = |(m_pend & m_mask);
            for (int n = 0; n < 2; n++) begin
                if (EV_IN[n]) m_ts[n] = m_ts_cnt;
                if (wr && o == ((n == 0) ? 8'h08 : 8'h0C)) m_cnt[n] = EV_IN[n] ? 1 : 0;
                else if (EV_IN[n] && m_cnt[n] < CNT_MAX) m_cnt[n] = m_cnt[n] + 1;
            end
            m_ts_cnt = m_ts_cnt + 1;
            if (wr && o == 8'h00) m_pend = m_pend & ~PWDATA[1:0];
            m_pend = m_pend | EV_IN;
            if (wr && o == 8'h04) m_mask = PWDATA[1:0];
            m_irq = new_irq;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        model_edge();
        #1;
        check("irq", 32'(IRQ), 32'(m_irq));
    endtask

    task automatic idle();
        PSEL = 0; PENABLE = 0; PWRITE = 0; EV_IN = 2'b00;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] ev);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = addr; PWDATA = data; EV_IN = 2'b00;
        #1;
        check("wr_setup_pslverr", 32'(PSLVERR), 32'h0);
        tick();
        PENABLE = 1; EV_IN = ev;
        #1;
        check("wr_pslverr", 32'(PSLVERR), 32'(!legal(addr[7:0])));
        check("wr_prdata", PRDATA, 32'h0);
        tick();
        idle();
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic [1:0] ev);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = addr; EV_IN = 2'b00;
        tick();
        PENABLE = 1; EV_IN = ev;
        #1;
        check("rd_prdata", PRDATA, exp_rd(addr[7:0]));
        check("rd_pslverr", 32'(PSLVERR), 32'(!legal(addr[7:0])));
        tick();
        idle();
    endtask

    task automatic read_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = addr; EV_IN = 2'b00;
        tick();
        PENABLE = 1;
        #1;
        check(tag, PRDATA, exp);
        tick();
        idle();
    endtask

    logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h02};

    initial begin
        logic [7:0]  o;
        logic [31:0] a;
        m_reset();
        PRESET = 1; PADDR = 0; PWDATA = 0; idle();
        #1;
        check("rst_irq", 32'(IRQ), 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        check("rst_prdata_idle", PRDATA, 32'h0);
        tick();
        #2 PRESET = 0;
        for (int i = 0; i < 7; i++) apb_read(32'(offs[i]), 2'b00);
        check("idle_prdata", PRDATA, 32'h0);

`ifdef EVT_TIMESTAMP_EN
        for (int i = 0; i < 200 && m_ts_cnt != 32'h64; i++) tick();
        EV_IN = 2'b01; tick(); EV_IN = 2'b00;
        read_expect("ts0_at_0x64", 32'h10, 32'h64);
        apb_read(32'h18, 2'b00);
`endif

        // Event with mask enabled: IRQ latency and counter
        apb_write(32'h00, 32'h3, 2'b00);
        apb_write(32'h08, 32'h0, 2'b00);
        apb_write(32'h04, 32'h3, 2'b00);
        EV_IN = 2'b01; tick(); EV_IN = 2'b00;
        check("ev_irq_edge1", 32'(IRQ), 32'h0);
        tick();
        check("ev_irq_edge2", 32'(IRQ), 32'h1);
        read_expect("ev_status", 32'h00, 32'h1);
        read_expect("ev_count0", 32'h08, 32'h1);

        // W1C colliding with an event on the same bit
        apb_write(32'h00, 32'h1, 2'b01);
        read_expect("w1c_collide_status", 32'h00, 32'h1);
        read_expect("w1c_collide_count0", 32'h08, 32'h2);

        // Saturation and clear of COUNT1
        EV_IN = 2'b10;
        for (int i = 0; i < 260; i++) tick();
        EV_IN = 2'b00;
        read_expect("count1_sat", 32'h0C, 32'hFF);
        apb_write(32'h0C, 32'hDEAD, 2'b00);
        read_expect("count1_clr", 32'h0C, 32'h0);
        apb_write(32'h08, 32'h0, 2'b01);
        read_expect("count0_clr_with_ev", 32'h08, 32'h1);

        // Both channels together, mask on channel 1 only
        apb_write(32'h00, 32'h3, 2'b00);
        apb_write(32'h04, 32'h2, 2'b00);
        tick();
        EV_IN = 2'b11; tick(); EV_IN = 2'b00;
        tick();
        check("both_irq", 32'(IRQ), 32'h1);
        read_expect("both_status", 32'h00, 32'h3);
        apb_write(32'h00, 32'h2, 2'b00);
        check("w1c2_irq_same", 32'(IRQ), 32'h1);
        tick();
        check("w1c2_irq_low", 32'(IRQ), 32'h0);
        read_expect("w1c2_status", 32'h00, 32'h1);

        // Unmapped offsets
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h1C;
        tick();
        PENABLE = 1;
        #1;
        check("bad_rd_pslverr", 32'(PSLVERR), 32'h1);
        check("bad_rd_prdata", PRDATA, 32'h0);
        tick(); idle();
        apb_write(32'h20, 32'h3, 2'b00);
        read_expect("bad_wr_mask", 32'h04, 32'h2);
        apb_write(32'h18, 32'hFFFF_FFFF, 2'b00);
        apb_write(32'h10, 32'hFFFF_FFFF, 2'b00);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            o = offs[$urandom_range(0, 9)];
            a = ($urandom() & 32'hFFFF_FF00) | 32'(o);
            case ($urandom_range(0, 2))
                0: begin
                    EV_IN = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
                    tick();
                    EV_IN = 2'b00;
                end
                1: apb_write(a, $urandom(), 2'($urandom_range(0, 3) & $urandom_range(0, 3)));
                default: apb_read(a, 2'($urandom_range(0, 3) & $urandom_range(0, 3)));
            endcase
        end

        // Async reset in the middle of an access
        apb_write(32'h04, 32'h3, 2'b00);
        EV_IN = 2'b11; tick(); EV_IN = 2'b00;
        tick();
        check("pre_rst_irq", 32'(IRQ), 32'h1);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h08; PWDATA = 0;
        tick();
        PENABLE = 1;
        #1 PRESET = 1;
        m_reset();
        #1;
        check("async_rst_irq", 32'(IRQ), 32'h0);
        check("async_rst_pready", 32'(PREADY), 32'h1);
        PWRITE = 0;
        for (int i = 0; i < 7; i++) begin
            PADDR = 32'(offs[i]);
            EV_IN = 2'b11;
            #1;
            check("async_rst_reg", PRDATA, 32'h0);
        end
        tick();
        tick();
        idle();
        #2 PRESET = 0;
        tick();
        for (int i = 0; i < 4; i++) read_expect("post_rst_reg", 32'(offs[i]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
